imm_packer: RTL

Streaming RISC-V instruction encoder that does the inverse of immediate extraction. It accepts decoded fields plus a 32-bit immediate and a format select, range-checks the immediate, and scatters its bits into a 32-bit instruction word. Output words carry a sequential word address and form a valid/ready stream that writes the instruction memory during FPGA boot loading or self-test.

---
 rtl/imm_packer_pkg.sv | 31 +++
 rtl/imm_packer_scatter.sv | 56 +++++
 rtl/imm_packer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/imm_packer_pkg.sv
// imm_packer_pkg: shared definitions for the instruction packer.
//   - ext_sel_e : format select encoding (extends the extractor's I/S/B/U/J with R)
//   - state_e   : packer FSM state encoding
//   - upper_uniform() : true when imm[31:lsb] are all equal (value fits as signed)
package imm_packer_pkg;

    typedef enum logic [2:0] {
        EXT_I = 3'd0,
        EXT_S = 3'd1,
        EXT_B = 3'd2,
        EXT_U = 3'd3,
        EXT_J = 3'd4,
        EXT_R = 3'd5
    } ext_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_e;

    // An arithmetic shift right by lsb sign-extends bit 31 over the kept
    // field, so imm[31:lsb] is uniform exactly when the result is all zeros
    // or all ones.
    function automatic logic upper_uniform(input logic [31:0] v, input logic [4:0] lsb);
        logic [31:0] shifted;
        shifted = $signed(v) >>> lsb;
        return (shifted == 32'h0000_0000) || (shifted == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/imm_packer_scatter.sv
// imm_scatter: combinational RISC-V encoder core.
//   in : sel_ext (format), opcode, rd, funct3, rs1, rs2, funct7, imm
//   out: instr (packed instruction word), legal (format valid and imm encodable)
// Fields a format does not carry are left out of the word entirely.
module imm_scatter
    import imm_packer_pkg::*;
(
    input  logic [2:0]  sel_ext,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    // Scatter immediate bits per format and judge encodability.
    always_comb begin
        instr = 32'h0000_0000;
        legal = 1'b0;
        case (sel_ext)
            EXT_I: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                legal = upper_uniform(imm, 5'd11);
            end
            EXT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = upper_uniform(imm, 5'd11);
            end
            EXT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = upper_uniform(imm, 5'd12) && (imm[0] == 1'b0);
            end
            EXT_U: begin
                instr = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'h000);
            end
            EXT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = upper_uniform(imm, 5'd20) && (imm[0] == 1'b0);
            end
            EXT_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            default: begin
                instr = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_packer.sv
// imm_packer: streaming instruction encoder feeding an instruction-memory writer.
//   clk, rst (async, active high), start (clear + enter RUN)
//   in_valid/in_ready + sel_ext, opcode, rd, funct3, rs1, rs2, funct7, imm : input words
//   out_valid/out_ready + out_instr, out_addr : encoded words with sequential address
//   err_range, err_sel : sticky error flags; full : last address written
// Illegal words are consumed silently (flag only), so the address sequence
// only counts words that actually reach memory.
module imm_packer
    import imm_packer_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        sel_ext,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_range,
    output logic              err_sel,
    output logic              full
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    state_e            state_next_s;
    logic              in_ready_s;
    logic              out_valid_r;
    logic [31:0]       out_instr_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              err_range_r;
    logic              err_sel_r;
    logic              full_r;
    logic [31:0]       scat_instr_s;
    logic              scat_legal_s;
    logic              sel_bad_s;
    logic              in_hs_s;
    logic              out_hs_s;
    logic              at_top_s;

    imm_scatter u_scatter (
        .sel_ext (sel_ext),
        .opcode  (opcode),
        .rd      (rd),
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct7  (funct7),
        .imm     (imm),
        .instr   (scat_instr_s),
        .legal   (scat_legal_s)
    );

    assign sel_bad_s = sel_ext[2] & sel_ext[1];
    assign in_hs_s   = in_valid & in_ready_s;
    assign out_hs_s  = out_valid_r & out_ready;
    // out_addr_r always names the word in (or next into) the output register.
    assign at_top_s  = (out_addr_r == TOP_ADDR);

    // State register; full mirrors the FULL state as a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            full_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            full_r  <= (state_next_s == FULL);
        end
    end

    // Next-state logic; start overrides every state.
    always_comb begin
        state_next_s = state_r;
        if (start) begin
            state_next_s = RUN;
        end else begin
            case (state_r)
                IDLE: state_next_s = IDLE;
                RUN: begin
                    if (out_hs_s && at_top_s) begin
                        state_next_s = FULL;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                FULL:    state_next_s = FULL;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Input ready; holding the top-address word blocks further input so
    // nothing can be accepted past the end of memory.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            RUN: begin
                if (start) begin
                    in_ready_s = 1'b0;
                end else if (out_valid_r && at_top_s) begin
                    in_ready_s = 1'b0;
                end else begin
                    in_ready_s = !out_valid_r || out_ready;
                end
            end
            IDLE:    in_ready_s = 1'b0;
            FULL:    in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Output register, address counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_addr_r  <= {ADDR_W{1'b0}};
            err_range_r <= 1'b0;
            err_sel_r   <= 1'b0;
        end else if (start) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_addr_r  <= {ADDR_W{1'b0}};
            err_range_r <= 1'b0;
            err_sel_r   <= 1'b0;
        end else begin
            // Saturate at the top address: FULL is entered instead of wrapping.
            if (out_hs_s && !at_top_s) begin
                out_addr_r <= out_addr_r + ADDR_ONE;
            end else begin
                out_addr_r <= out_addr_r;
            end
            // A new legal word replaces one leaving in the same cycle.
            if (in_hs_s && scat_legal_s) begin
                out_valid_r <= 1'b1;
                out_instr_r <= scat_instr_s;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (in_hs_s && !scat_legal_s) begin
                if (sel_bad_s) begin
                    err_sel_r <= 1'b1;
                end else begin
                    err_range_r <= 1'b1;
                end
            end else begin
                err_sel_r   <= err_sel_r;
                err_range_r <= err_range_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_instr = out_instr_r;
    assign out_addr  = out_addr_r;
    assign err_range = err_range_r;
    assign err_sel   = err_sel_r;
    assign full      = full_r;

endmodule
